// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;

endpackage

// File: rtl/rf_arb_grant.sv
// One-hot grant selection: fixed lowest-index priority, or round-robin from
// ptr when RF_ARB_ROUND_ROBIN_EN is defined.
module rf_arb_grant
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = 1
) (
`ifdef RF_ARB_ROUND_ROBIN_EN
  input  logic [PTR_W-1:0]   ptr,
`endif
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  always_comb begin
    logic               found;
    logic [NUM_REQ-1:0] sh;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    sh    = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      idx = (32'(ptr) + k) % NUM_REQ;
`else
      idx = k;
`endif
      sh = valid >> idx;
      if (!found && sh[0]) begin
        grant = ONE << idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the single register-file write
// port. Optional round-robin arbitration: RF_ARB_ROUND_ROBIN_EN.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rf_stall,
  output logic [ADDR_W-1:0]         dec_d,
  output logic                      dec_e,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state, state_nx;
  logic                open;
  logic [NUM_REQ-1:0]  grant;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                accepted;
  logic                write_nz;

  // Requests are only offered while the output stage is empty or draining.
  assign open = !reset && ((state == IDLE) || (state == WRITE && !rf_stall));

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;

  rf_arb_grant #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_grant (
    .ptr   (ptr),
    .valid (open ? req_valid : '0),
    .grant (grant)
  );
`else
  rf_arb_grant #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_grant (
    .valid (open ? req_valid : '0),
    .grant (grant)
  );
`endif

  assign req_ready = grant;
  assign accepted  = |grant;

  always_comb begin
    logic [NUM_REQ-1:0] gbit;
    sel_addr = '0;
    sel_data = '0;
    gbit     = '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
    win_idx  = '0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gbit = grant >> i;
      if (gbit[0]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
`ifdef RF_ARB_ROUND_ROBIN_EN
        win_idx  = PTR_W'(i);
`endif
      end
    end
  end

  // A grant to R0 completes the handshake but never reaches the decoder.
  assign write_nz = accepted && (sel_addr != ADDR_W'(REG_ZERO));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = write_nz ? WRITE : IDLE;
      WRITE:   state_nx = rf_stall ? HOLD : (write_nz ? WRITE : IDLE);
      HOLD:    state_nx = rf_stall ? HOLD : WRITE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dec_d   <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      if (open && write_nz) begin
        dec_d   <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

`ifdef RF_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accepted) begin
      if (win_idx == PTR_W'(NUM_REQ - 1)) ptr <= '0;
      else                                ptr <= win_idx + 1'b1;
    end
  end
`endif

  assign dec_e = (state != IDLE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (NUM_REQ=2).
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        rf_stall;
  logic [4:0]  dec_d;
  logic        dec_e;
  logic [31:0] wr_data;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_stall  (rf_stall),
    .dec_d     (dec_d),
    .dec_e     (dec_e),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive point is just after the rising edge; checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    rf_stall = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_addr  = 'x;
    req_data  = 'x;
    rf_stall  = 1'b0;

    // Reset state
    do_reset();
    sample();
    check("rst_dec_d", 64'(dec_d), 64'd0);
    check("rst_dec_e", 64'(dec_e), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);

    // Single write, one-cycle latency
    next_cycle();
    req_valid = 2'b01;
    req_addr  = {5'bx, 5'd3};
    req_data  = {32'bx, 32'hDEADBEEF};
    sample();
    check("t1_ready", 64'(req_ready), 64'b01);
    check("t1_pre_dec_e", 64'(dec_e), 64'd0);
    next_cycle();
    req_valid = 2'b00;
    req_addr  = 'x;
    req_data  = 'x;
    sample();
    check("t1_dec_d", 64'(dec_d), 64'd3);
    check("t1_dec_e", 64'(dec_e), 64'd1);
    check("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
    check("t1_busy", 64'(busy), 64'd1);
    next_cycle();
    sample();
    check("t1_idle_dec_e", 64'(dec_e), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // Two simultaneous requests serialize 0 then 1
    do_reset();
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {32'h22222222, 32'h11111111};
    sample();
    check("t2_c1_ready", 64'(req_ready), 64'b01);
    next_cycle();
    req_valid = 2'b10;
    sample();
    check("t2_c2_ready", 64'(req_ready), 64'b10);
    check("t2_c2_dec_d", 64'(dec_d), 64'd1);
    check("t2_c2_wr_data", 64'(wr_data), 64'h11111111);
    next_cycle();
    req_valid = 2'b00;
    sample();
    check("t2_c3_dec_d", 64'(dec_d), 64'd2);
    check("t2_c3_dec_e", 64'(dec_e), 64'd1);
    check("t2_c3_wr_data", 64'(wr_data), 64'h22222222);
    next_cycle();
    sample();
    check("t2_c4_dec_e", 64'(dec_e), 64'd0);

    // Write to R0 is accepted but never issued
    next_cycle();
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd0};
    req_data  = {32'd0, 32'h1234};
    sample();
    check("t3_ready", 64'(req_ready), 64'b01);
    check("t3_c0_dec_e", 64'(dec_e), 64'd0);
    next_cycle();
    req_valid = 2'b00;
    sample();
    check("t3_c1_dec_e", 64'(dec_e), 64'd0);
    check("t3_c1_busy", 64'(busy), 64'd0);
    next_cycle();
    sample();
    check("t3_c2_dec_e", 64'(dec_e), 64'd0);

    // Stall for three cycles holds the write to r31
    do_reset();
    req_valid = 2'b01;
    req_addr  = {5'd4, 5'd31};
    req_data  = {32'h44444444, 32'hCAFE0031};
    sample();
    check("t4_accept", 64'(req_ready), 64'b01);
    next_cycle();
    req_valid = 2'b11;
    rf_stall  = 1'b1;
    sample();
    check("t4_s1_dec_d", 64'(dec_d), 64'd31);
    check("t4_s1_dec_e", 64'(dec_e), 64'd1);
    check("t4_s1_ready", 64'(req_ready), 64'b00);
    next_cycle();
    sample();
    check("t4_s2_dec_d", 64'(dec_d), 64'd31);
    check("t4_s2_dec_e", 64'(dec_e), 64'd1);
    check("t4_s2_ready", 64'(req_ready), 64'b00);
    next_cycle();
    sample();
    check("t4_s3_dec_e", 64'(dec_e), 64'd1);
    check("t4_s3_wr_data", 64'(wr_data), 64'hCAFE0031);
    check("t4_s3_ready", 64'(req_ready), 64'b00);
    next_cycle();
    rf_stall  = 1'b0;
    req_valid = 2'b00;
    sample();
    check("t4_r1_dec_d", 64'(dec_d), 64'd31);
    check("t4_r1_dec_e", 64'(dec_e), 64'd1);
    next_cycle();
    sample();
    check("t4_r2_dec_e", 64'(dec_e), 64'd1);
    check("t4_r2_dec_d", 64'(dec_d), 64'd31);
    next_cycle();
    sample();
    check("t4_done_dec_e", 64'(dec_e), 64'd0);

    // Reset while in HOLD discards the pending write
    next_cycle();
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd7};
    req_data  = {32'd0, 32'h77777777};
    next_cycle();
    req_valid = 2'b00;
    rf_stall  = 1'b1;
    next_cycle();
    sample();
    check("t5_hold_busy", 64'(busy), 64'd1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    sample();
    check("t5_rst_dec_e", 64'(dec_e), 64'd0);
    check("t5_rst_dec_d", 64'(dec_d), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    reset    = 1'b0;
    rf_stall = 1'b0;
    next_cycle();
    sample();
    check("t5_post1_dec_e", 64'(dec_e), 64'd0);
    next_cycle();
    sample();
    check("t5_post2_dec_e", 64'(dec_e), 64'd0);

    // Both requesters held valid for four cycles
    next_cycle();
    req_valid = 2'b11;
    req_addr  = {5'd9, 5'd8};
    req_data  = {32'h99999999, 32'h88888888};
    for (int c = 0; c < 4; c++) begin
      logic [1:0] exp_g;
`ifdef RF_ARB_ROUND_ROBIN_EN
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      sample();
      check($sformatf("t6_grant%0d", c), 64'(req_ready), 64'(exp_g));
      next_cycle();
      sample();
      check($sformatf("t6_dec_d%0d", c), 64'(dec_d), (exp_g == 2'b01) ? 64'd8 : 64'd9);
    end
    req_valid = 2'b00;
    next_cycle();
    next_cycle();
    sample();
    check("t6_drain_dec_e", 64'(dec_e), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-file write port, driven through the 5-to-32 binary decoder (D = address, E = enable), between NUM_REQ writeback requesters, for example the ALU and load writeback paths. Requests use valid/ready handshakes. The block registers one winning write per cycle and presents it as decoder address/enable plus write data. It sits between the execute/memory writeback stages and the register file.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4)
DATA_W, 32, register data width
ADDR_W, 5, register address width (decoder input width; 32 registers)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed destination register addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data; same packing as req_addr
req_ready  output  NUM_REQ  per-requester accept; handshake completes when valid&ready are both high at a rising edge
rf_stall  input  1  register file cannot accept a write this cycle
dec_d  output  ADDR_W  decoder address input D
dec_e  output  1  decoder enable E (register write strobe)
wr_data  output  DATA_W  data to the register file
busy  output  1  output stage holds a write not yet consumed

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: dec_d=0, dec_e=0, wr_data=0, busy=0, req_ready=0, arbitration pointer=0, FSM=IDLE.
- FSM states:
  - IDLE: output stage empty.
  - WRITE: dec_e=1 for the registered write.
  - HOLD: write pending while rf_stall=1.
- IDLE transitions: on any accepted request go to WRITE the next cycle; otherwise stay in IDLE.
- WRITE transitions:
  - If rf_stall=0, the write is consumed this cycle. With a new grant, stay in WRITE with new contents; with no grant, go to IDLE.
  - If rf_stall=1, go to HOLD.
- HOLD: keep dec_d, dec_e and wr_data frozen. Return to WRITE when rf_stall drops.
- req_ready is combinational. At most one bit is high per cycle. A bit may be high only when the output stage is empty or being consumed this cycle (state IDLE, or WRITE with rf_stall=0).
- Latency: a request accepted at edge N appears as dec_e=1 from edge N through edge N+1 (one registered stage). Throughput is one write per cycle with no stalls.
- Arbitration (default): fixed priority, lowest index wins.
- R0 rule: a request with addr=0 is accepted (ready=1), but the FSM stays or returns to IDLE with dec_e=0. R0 is hardwired zero and is never written.
- Unasserted valid: addr/data are ignored; X on them must not propagate to dec_e.
- Simultaneous requests with the same address: only the winner is accepted. The loser is written the next cycle, so it wins WAW ordering (the later write persists).
- rf_stall asserted in IDLE: no effect. Requests are still accepted into the output stage, which then goes to HOLD.
- Reset mid-HOLD: the pending write is discarded and dec_e=0 next cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: RF_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The pointer advances to one past the last granted index on every accepted handshake, wraps from NUM_REQ-1 to 0, and is unchanged when no grant occurs.
- Undefined: fixed priority, lowest index wins; the pointer logic is absent.

Decomposition:
- Package rf_arb_pkg holds:
  - state encoding typedef (IDLE=2'd0, WRITE=2'd1, HOLD=2'd2);
  - REG_ZERO=5'd0;
  - default widths.
- Sub-module rf_arb_grant holds the combinational grant selection (fixed or round-robin, pointer input) and returns a one-hot grant.
- The FSM and output register stay in the top level.

Test Plan:
- Reset, then req0 valid (addr=5'd3, data=32'hDEADBEEF): ready0=1; the next cycle dec_d=3, dec_e=1, wr_data=DEADBEEF.
- req0 (addr=1) and req1 (addr=2) valid together: cycle 1 grants req0, cycle 2 grants req1. dec_d sequence is 1 then 2; req1 ready only in cycle 2.
- Write to addr=0 with data=32'h1234: ready=1, dec_e stays 0 for all cycles, busy=0.
- rf_stall=1 for 3 cycles while a write (addr=5'd31) is pending: dec_d=31 and dec_e=1 are held, req_ready=0 throughout. The write completes on the first cycle with rf_stall=0.
- Assert reset during HOLD: the next cycle dec_e=0, dec_d=0, busy=0, and no write is issued after release.
- With RF_ARB_ROUND_ROBIN_EN defined, hold both requesters valid for 4 cycles: grants alternate 0,1,0,1. Without the macro, grants are 0,0,0,0.
